// File: rtl/ipv4_pkg.sv
// IPv4 receive filter shared definitions.
// States, drop codes, header offsets and ones-complement helper.
package ipv4_pkg;

    // Parser states
    localparam logic [2:0] S_HDR     = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_PAD     = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    // Drop reason codes
    localparam logic [2:0] DR_NONE    = 3'd0;
    localparam logic [2:0] DR_BAD_HDR = 3'd1;
    localparam logic [2:0] DR_TRUNC   = 3'd2;
    localparam logic [2:0] DR_BAD_LEN = 3'd3;
    localparam logic [2:0] DR_FRAG    = 3'd4;
    localparam logic [2:0] DR_PROTO   = 3'd5;
    localparam logic [2:0] DR_CSUM    = 3'd6;
    localparam logic [2:0] DR_DST     = 3'd7;

    // Header byte offsets
    localparam logic [5:0] OFF_VER_IHL = 6'd0;
    localparam logic [5:0] OFF_TLEN_HI = 6'd2;
    localparam logic [5:0] OFF_TLEN_LO = 6'd3;
    localparam logic [5:0] OFF_FLAGS   = 6'd6;
    localparam logic [5:0] OFF_FRAG_LO = 6'd7;
    localparam logic [5:0] OFF_PROTO   = 6'd9;
    localparam logic [5:0] OFF_SRC     = 6'd12;
    localparam logic [5:0] OFF_DST     = 6'd16;

    localparam int IPV4_MIN_HDR = 20;

    // Fields captured while the header streams past
    typedef struct packed {
        logic [15:0] tot_len;
        logic        mf;
        logic [12:0] frag_off;
        logic [7:0]  proto;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ipv4_hdr_t;

    // 16-bit ones-complement add with end-around carry
    function automatic logic [15:0] oc_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Byte-serial ones-complement 16-bit accumulator.
// Even bytes land in the high half of a word, odd bytes in the low half.
module ip_csum_acc
    import ipv4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic        odd,
    input  logic [7:0]  data,
    output logic [15:0] sum
);

    logic [15:0] addend;
    logic [15:0] base;

    // Position the byte in its word; clr restarts from zero
    always_comb begin
        addend = odd ? {8'h00, data} : {data, 8'h00};
        base   = clr ? 16'h0000 : sum;
    end

    // Running sum; clr together with byte_en starts a new header
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= 16'h0000;
        end else if (byte_en) begin
            sum <= oc_add(base, addend);
        end else if (clr) begin
            sum <= 16'h0000;
        end
    end

endmodule

// File: rtl/ipv4_rx_filter.sv
// IPv4 receive parser: header capture, checksum, filtering,
// pad stripping and payload pass-through with metadata on tuser.
module ipv4_rx_filter
    import ipv4_pkg::*;
#(
    parameter logic [31:0] TARGET_IP     = 32'hC0A80001,
    parameter logic [7:0]  PROTOCOL      = 8'd17,
    parameter bit          DST_FILTER_EN = 1'b1,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter bit          CHECKSUM_EN   = 1'b1,
    parameter int          IN_USER_W     = 18,
    parameter int          CNT_W         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic [IN_USER_W-1:0]    s_axis_tuser,
    output logic                    s_axis_tready,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic [IN_USER_W+79:0]   m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic                    drop_valid,
    output logic [2:0]              drop_reason,
    output logic                    short_err,
    output logic [CNT_W-1:0]        stat_rx_ok,
    output logic [CNT_W-1:0]        stat_drop
);

    logic [2:0]             state;
    logic [5:0]             hdr_cnt;
    logic [3:0]             ihl;
    logic [5:0]             hdr_len;
    logic [15:0]            hdr_len16;
    logic [15:0]            pay_len;
    ipv4_hdr_t              hdr;
    logic [IN_USER_W-1:0]   in_user;
    logic [15:0]            remain;
    logic [IN_USER_W+79:0]  user_q;
    logic [15:0]            csum;

    logic       accept;
    logic       hdr_acc;
    logic       hdr_last;
    logic       byte0_bad;
    logic       dst_ok;
    logic [2:0] chk_reason;
    logic       drop_evt;
    logic [2:0] drop_code;
    logic       pay_acc;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign hdr_acc   = (state == S_HDR) && accept;
    assign pay_acc   = (state == S_PAYLOAD) && accept;
    assign hdr_len   = {ihl, 2'b00};
    assign hdr_len16 = {10'd0, hdr_len};
    assign pay_len   = hdr.tot_len - hdr_len16;
    assign hdr_last  = (hdr_cnt != 6'd0) && (hdr_cnt == hdr_len - 6'd1);
    assign byte0_bad = (s_axis_tdata[7:4] != 4'd4) || (s_axis_tdata[3:0] < 4'd5);
    assign dst_ok    = (hdr.dst_ip == TARGET_IP) ||
                       (ACCEPT_BCAST && (hdr.dst_ip == 32'hFFFF_FFFF));
    assign m_axis_tuser = user_q;

    ip_csum_acc u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state == S_HDR) && (hdr_cnt == 6'd0)),
        .byte_en (hdr_acc),
        .odd     (hdr_cnt[0]),
        .data    (s_axis_tdata),
        .sum     (csum)
    );

    // Handshake steering: payload passes straight through, others sink
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        unique case (state)
            S_HDR, S_PAD, S_DROP: s_axis_tready = 1'b1;
            S_CHECK:              s_axis_tready = 1'b0;
            S_PAYLOAD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = (remain == 16'd1) | s_axis_tlast;
            end
            default: ;
        endcase
    end

    // Header verdict, first failing check in priority order wins
    always_comb begin
        chk_reason = DR_NONE;
        if (hdr.tot_len <= hdr_len16) begin
            chk_reason = DR_BAD_LEN;
        end else if (hdr.mf || (hdr.frag_off != 13'd0)) begin
            chk_reason = DR_FRAG;
        end else if (hdr.proto != PROTOCOL) begin
            chk_reason = DR_PROTO;
        end else if (CHECKSUM_EN && (csum != 16'hFFFF)) begin
            chk_reason = DR_CSUM;
        end else if (DST_FILTER_EN && !dst_ok) begin
            chk_reason = DR_DST;
        end
    end

    // Drop events from header truncation, bad byte 0 or the verdict
    always_comb begin
        drop_evt  = 1'b0;
        drop_code = DR_NONE;
        if (hdr_acc) begin
            if (s_axis_tlast) begin
                drop_evt  = 1'b1;
                drop_code = DR_TRUNC;
            end else if ((hdr_cnt == 6'd0) && byte0_bad) begin
                drop_evt  = 1'b1;
                drop_code = DR_BAD_HDR;
            end
        end else if ((state == S_CHECK) && (chk_reason != DR_NONE)) begin
            drop_evt  = 1'b1;
            drop_code = chk_reason;
        end
    end

    // Capture header fields as their bytes stream past
    always_ff @(posedge clk) begin
        if (rst) begin
            ihl     <= 4'd0;
            hdr     <= '0;
            in_user <= '0;
        end else if (hdr_acc) begin
            case (hdr_cnt)
                OFF_VER_IHL: begin
                    ihl     <= s_axis_tdata[3:0];
                    in_user <= s_axis_tuser;
                end
                OFF_TLEN_HI: hdr.tot_len[15:8] <= s_axis_tdata;
                OFF_TLEN_LO: hdr.tot_len[7:0]  <= s_axis_tdata;
                OFF_FLAGS: begin
                    hdr.mf              <= s_axis_tdata[5];
                    hdr.frag_off[12:8]  <= s_axis_tdata[4:0];
                end
                OFF_FRAG_LO: hdr.frag_off[7:0] <= s_axis_tdata;
                OFF_PROTO:   hdr.proto         <= s_axis_tdata;
                OFF_SRC,
                OFF_SRC + 6'd1,
                OFF_SRC + 6'd2,
                OFF_SRC + 6'd3:
                    hdr.src_ip <= {hdr.src_ip[23:0], s_axis_tdata};
                OFF_DST,
                OFF_DST + 6'd1,
                OFF_DST + 6'd2,
                OFF_DST + 6'd3:
                    hdr.dst_ip <= {hdr.dst_ip[23:0], s_axis_tdata};
                default: ;
            endcase
        end
    end

    // Packet state machine, header byte count and payload countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_HDR;
            hdr_cnt <= 6'd0;
            remain  <= 16'd0;
            user_q  <= '0;
        end else begin
            unique case (state)
                S_HDR: begin
                    if (accept) begin
                        if (s_axis_tlast) begin
                            hdr_cnt <= 6'd0;
                        end else if ((hdr_cnt == 6'd0) && byte0_bad) begin
                            hdr_cnt <= 6'd0;
                            state   <= S_DROP;
                        end else if (hdr_last) begin
                            hdr_cnt <= 6'd0;
                            state   <= S_CHECK;
                        end else begin
                            hdr_cnt <= hdr_cnt + 6'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (chk_reason == DR_NONE) begin
                        remain <= pay_len;
                        user_q <= {in_user, pay_len,
                                   hdr.src_ip, hdr.dst_ip};
                        state  <= S_PAYLOAD;
                    end else begin
                        state  <= S_DROP;
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        remain <= remain - 16'd1;
                        if (remain == 16'd1) begin
                            state <= s_axis_tlast ? S_HDR : S_PAD;
                        end else if (s_axis_tlast) begin
                            state <= S_HDR;
                        end
                    end
                end
                S_PAD, S_DROP: begin
                    if (accept && s_axis_tlast) begin
                        state <= S_HDR;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

    // Event pulses and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_valid  <= 1'b0;
            drop_reason <= 3'd0;
            short_err   <= 1'b0;
            stat_rx_ok  <= '0;
            stat_drop   <= '0;
        end else begin
            drop_valid  <= drop_evt;
            drop_reason <= drop_evt ? drop_code : 3'd0;
            short_err   <= pay_acc && s_axis_tlast &&
                           (remain != 16'd1);
            if (drop_evt && (stat_drop != '1)) begin
                stat_drop <= stat_drop + CNT_W'(1);
            end
            if (pay_acc && m_axis_tlast && (stat_rx_ok != '1)) begin
                stat_rx_ok <= stat_rx_ok + CNT_W'(1);
            end
        end
    end

endmodule
